// File: rtl/ecc_mem_array_if.sv
// ecc_mem_array_if: host-side bus of the SECDED register-file memory.
//
// Handshake: we and re are single-cycle request strobes that are always
// accepted (there is no ready; the memory never stalls the host). A read
// strobe in cycle N is answered by a one-cycle rvalid pulse in cycle N+1
// carrying rdata/rsbe/rdbe. Error counters and capture are level outputs.
//
// Signals:
//   we, waddr, wdata, inj_mask   write port (inj_mask XORed into codeword)
//   re, raddr                    read port request
//   rvalid, rdata, rsbe, rdbe    read response
//   sbe_count, dbe_count         saturating error counters
//   err_valid, err_addr, err_clr sticky first-error capture and its clear
//   scrub_busy                   scrubber in READ/CHECK/WRITE
//   scrub_state                  scrubber FSM state (debug visibility)
interface ecc_mem_array_if #(
  parameter int DATA_W = 57,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
);
  function automatic int calc_chk_w(input int dw);
    int r;
    r = 1;
    while ((1 << r) < (dw + r + 1)) r = r + 1;
    return r;
  endfunction

  localparam int CHK_W = calc_chk_w(DATA_W);
  localparam int CW_W  = DATA_W + CHK_W + 1;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [CW_W-1:0]   inj_mask;
  logic              re;
  logic [ADDR_W-1:0] raddr;
  logic              err_clr;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              rsbe;
  logic              rdbe;
  logic [CNT_W-1:0]  sbe_count;
  logic [CNT_W-1:0]  dbe_count;
  logic              err_valid;
  logic [ADDR_W-1:0] err_addr;
  logic              scrub_busy;
  logic [2:0]        scrub_state;

  modport master (
    output we, waddr, wdata, inj_mask, re, raddr, err_clr,
    input  rvalid, rdata, rsbe, rdbe, sbe_count, dbe_count,
           err_valid, err_addr, scrub_busy, scrub_state
  );

  modport slave (
    input  we, waddr, wdata, inj_mask, re, raddr, err_clr,
    output rvalid, rdata, rsbe, rdbe, sbe_count, dbe_count,
           err_valid, err_addr, scrub_busy, scrub_state
  );
endinterface

// File: rtl/ecc_mem_array.sv
// ecc_mem_array: SECDED-protected register-file memory with one write port,
// one registered read port, a background scrubber, saturating error counters
// and sticky first-error address capture.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset; clears all state and the array
//   bus   ecc_mem_array_if.slave (see interface file for signal list)
//
// Codeword layout: bit 0 is overall parity, bits 1..CW_W-1 are Hamming
// positions; check bit k at position 2^k, data bits fill the rest in order.
module ecc_mem_array #(
  parameter int DATA_W         = 57,
  parameter int ADDR_W         = 4,
  parameter int SCRUB_EN       = 1,
  parameter int SCRUB_INTERVAL = 1024,
  parameter int CNT_W          = 8
) (
  input logic           clk,
  input logic           rst,
  ecc_mem_array_if.slave bus
);
  function automatic int calc_chk_w(input int dw);
    int r;
    r = 1;
    while ((1 << r) < (dw + r + 1)) r = r + 1;
    return r;
  endfunction

  localparam int CHK_W = calc_chk_w(DATA_W);
  localparam int CW_W  = DATA_W + CHK_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int IW    = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sbe;
    logic              dbe;
  } dec_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_READ  = 3'd2,
    S_CHECK = 3'd3,
    S_WRITE = 3'd4
  } state_e;

  function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0]  cw;
    logic [CHK_W-1:0] syn;
    int               j;
    cw  = '0;
    syn = '0;
    j   = 0;
    for (int p = 1; p < CW_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[j];
        if (d[j]) syn = syn ^ CHK_W'(p);
        j = j + 1;
      end
    end
    // Each check bit only contributes its own bit to the syndrome, so the
    // data-only syndrome is exactly the check-bit vector that zeroes it.
    for (int k = 0; k < CHK_W; k++) cw[1 << k] = syn[k];
    cw[0] = ^cw[CW_W-1:1];
    return cw;
  endfunction

  function automatic dec_t decode(input logic [CW_W-1:0] cw);
    dec_t             r;
    logic [CHK_W-1:0] s;
    logic             par;
    logic [CW_W-1:0]  fixed;
    int               j;
    s = '0;
    for (int p = 1; p < CW_W; p++) begin
      if (cw[p]) s = s ^ CHK_W'(p);
    end
    par   = ^cw;
    fixed = cw;
    r     = '0;
    if (s == '0) begin
      r.sbe = par;
    end else if (par && (int'(s) <= CW_W - 1)) begin
      for (int p = 1; p < CW_W; p++) begin
        if (CHK_W'(p) == s) fixed[p] = ~fixed[p];
      end
      r.sbe = 1'b1;
    end else begin
      r.dbe = 1'b1;
    end
    j = 0;
    for (int p = 1; p < CW_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        r.data[j] = fixed[p];
        j = j + 1;
      end
    end
    return r;
  endfunction

  logic [CW_W-1:0]   mem_q [DEPTH];
  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [IW-1:0]     ivl_q;
  logic              busy_q;
  logic              rvalid_q, rsbe_q, rdbe_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] scrub_data_q;
  logic              scrub_sbe_q;
  logic              ev_sbe_q, ev_dbe_q;
  logic [ADDR_W-1:0] ev_addr_q;
  logic [CNT_W-1:0]  sbe_cnt_q, sbe_cnt_d, dbe_cnt_q, dbe_cnt_d;
  logic              err_valid_q, err_valid_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  logic              host_rd, scrub_rd, scrub_wr, host_hit;
  logic [ADDR_W-1:0] rd_addr;
  dec_t              dec;

  // The host always owns the read port; the scrubber only reads when idle.
  assign host_rd  = bus.re;
  assign scrub_rd = (state_q == S_READ) && !bus.re;
  assign rd_addr  = bus.re ? bus.raddr : ptr_q;
  assign scrub_wr = (state_q == S_WRITE) && !bus.we;
  assign host_hit = bus.we && (bus.waddr == ptr_q);

  always_comb begin
    dec = decode(mem_q[rd_addr]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (bus.we) begin
      mem_q[bus.waddr] <= encode(bus.wdata) ^ bus.inj_mask;
    end else if (scrub_wr) begin
      mem_q[ptr_q] <= encode(scrub_data_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      rsbe_q       <= 1'b0;
      rdbe_q       <= 1'b0;
      scrub_data_q <= '0;
      scrub_sbe_q  <= 1'b0;
      ev_sbe_q     <= 1'b0;
      ev_dbe_q     <= 1'b0;
      ev_addr_q    <= '0;
    end else begin
      rvalid_q <= host_rd;
      rsbe_q   <= host_rd && dec.sbe;
      rdbe_q   <= host_rd && dec.dbe;
      if (host_rd) rdata_q <= dec.data;
      if (scrub_rd) begin
        scrub_data_q <= dec.data;
        scrub_sbe_q  <= dec.sbe;
      end
      ev_sbe_q <= (host_rd || scrub_rd) && dec.sbe;
      ev_dbe_q <= (host_rd || scrub_rd) && dec.dbe;
      if (host_rd || scrub_rd) ev_addr_q <= rd_addr;
    end
  end

  // Clear is applied first, then any error event of the same cycle.
  always_comb begin
    sbe_cnt_d   = bus.err_clr ? '0 : sbe_cnt_q;
    dbe_cnt_d   = bus.err_clr ? '0 : dbe_cnt_q;
    err_valid_d = bus.err_clr ? 1'b0 : err_valid_q;
    err_addr_d  = bus.err_clr ? '0 : err_addr_q;
    if (ev_sbe_q && (sbe_cnt_d != '1)) sbe_cnt_d = sbe_cnt_d + CNT_W'(1);
    if (ev_dbe_q && (dbe_cnt_d != '1)) dbe_cnt_d = dbe_cnt_d + CNT_W'(1);
    if ((ev_sbe_q || ev_dbe_q) && !err_valid_d) begin
      err_valid_d = 1'b1;
      err_addr_d  = ev_addr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sbe_cnt_q   <= '0;
      dbe_cnt_q   <= '0;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      sbe_cnt_q   <= sbe_cnt_d;
      dbe_cnt_q   <= dbe_cnt_d;
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
    end
  end

  // Scrubber. A host write landing on the scrubbed word while in CHECK or
  // WRITE makes the pending write-back stale, so it is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      ivl_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (SCRUB_EN != 0) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (ivl_q == IW'(SCRUB_INTERVAL - 1)) begin
            ivl_q   <= '0;
            state_q <= S_READ;
            busy_q  <= 1'b1;
          end else begin
            ivl_q <= ivl_q + IW'(1);
          end
        end
        S_READ: begin
          if (!bus.re) state_q <= S_CHECK;
        end
        S_CHECK: begin
          if (scrub_sbe_q && !host_hit) begin
            state_q <= S_WRITE;
          end else begin
            ptr_q   <= ptr_q + ADDR_W'(1);
            state_q <= S_WAIT;
            busy_q  <= 1'b0;
          end
        end
        S_WRITE: begin
          if (!bus.we || host_hit) begin
            ptr_q   <= ptr_q + ADDR_W'(1);
            state_q <= S_WAIT;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rvalid      = rvalid_q;
  assign bus.rdata       = rdata_q;
  assign bus.rsbe        = rsbe_q;
  assign bus.rdbe        = rdbe_q;
  assign bus.sbe_count   = sbe_cnt_q;
  assign bus.dbe_count   = dbe_cnt_q;
  assign bus.err_valid   = err_valid_q;
  assign bus.err_addr    = err_addr_q;
  assign bus.scrub_busy  = busy_q;
  assign bus.scrub_state = state_q;
endmodule

// File: tb/tb_ecc_mem_array.sv
// Testbench for ecc_mem_array. Instance a has the scrubber disabled and is
// used for host-path decode, counters, saturation and clear; instance b has a
// 4-cycle scrub interval and is used for repair, cancel and reset-in-WRITE.
module tb_ecc_mem_array;
  localparam int DW = 57;
  localparam int AW = 4;
  localparam int CW = 64;

  // clock / reset
  logic clk;
  logic rst_v [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // per-instance drive variables (index 0 = a, 1 = b)
  logic          we_v    [2];
  logic [AW-1:0] waddr_v [2];
  logic [DW-1:0] wdata_v [2];
  logic [CW-1:0] mask_v  [2];
  logic          re_v    [2];
  logic [AW-1:0] raddr_v [2];
  logic          clr_v   [2];

  ecc_mem_array_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(2)) bus_a ();
  ecc_mem_array_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(2)) bus_b ();

  assign bus_a.we = we_v[0];       assign bus_b.we = we_v[1];
  assign bus_a.waddr = waddr_v[0]; assign bus_b.waddr = waddr_v[1];
  assign bus_a.wdata = wdata_v[0]; assign bus_b.wdata = wdata_v[1];
  assign bus_a.inj_mask = mask_v[0]; assign bus_b.inj_mask = mask_v[1];
  assign bus_a.re = re_v[0];       assign bus_b.re = re_v[1];
  assign bus_a.raddr = raddr_v[0]; assign bus_b.raddr = raddr_v[1];
  assign bus_a.err_clr = clr_v[0]; assign bus_b.err_clr = clr_v[1];

  ecc_mem_array #(.DATA_W(DW), .ADDR_W(AW), .SCRUB_EN(0), .SCRUB_INTERVAL(4), .CNT_W(2))
    u_a (.clk(clk), .rst(rst_v[0]), .bus(bus_a));
  ecc_mem_array #(.DATA_W(DW), .ADDR_W(AW), .SCRUB_EN(1), .SCRUB_INTERVAL(4), .CNT_W(2))
    u_b (.clk(clk), .rst(rst_v[1]), .bus(bus_b));

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [DW+1:0] exp_a [$];
  logic [DW+1:0] exp_b [$];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // monitors: every response pulse pops one expectation {sbe, dbe, data}
  always @(negedge clk) begin
    logic [DW+1:0] e;
    if (bus_a.rvalid === 1'b1) begin
      if (exp_a.size() == 0) begin
        n_checks++;
        $display("FAIL a_unexpected_rvalid: got rvalid=1 expected no response");
      end else begin
        e = exp_a.pop_front();
        check("a_resp", {5'b0, bus_a.rsbe, bus_a.rdbe, bus_a.rdata}, {5'b0, e});
      end
    end
    if (bus_b.rvalid === 1'b1) begin
      if (exp_b.size() == 0) begin
        n_checks++;
        $display("FAIL b_unexpected_rvalid: got rvalid=1 expected no response");
      end else begin
        e = exp_b.pop_front();
        check("b_resp", {5'b0, bus_b.rsbe, bus_b.rdbe, bus_b.rdata}, {5'b0, e});
      end
    end
  end

  // driver tasks
  task automatic do_write(input int sel, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [CW-1:0] m);
    we_v[sel] = 1'b1; waddr_v[sel] = a; wdata_v[sel] = d; mask_v[sel] = m;
    @(posedge clk); #1;
    we_v[sel] = 1'b0; mask_v[sel] = '0;
  endtask

  task automatic push_exp(input int sel, input logic [DW-1:0] ed, input logic es, input logic eb);
    if (sel == 0) exp_a.push_back({es, eb, ed});
    else exp_b.push_back({es, eb, ed});
  endtask

  task automatic do_read(input int sel, input logic [AW-1:0] a, input logic [DW-1:0] ed,
                         input logic es, input logic eb);
    re_v[sel] = 1'b1; raddr_v[sel] = a;
    push_exp(sel, ed, es, eb);
    @(posedge clk); #1;
    re_v[sel] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_err(input int sel, input string tag, input int es, input int eb,
                         input logic ev, input logic [AW-1:0] ea);
    if (sel == 0) begin
      check({tag, "_sbe_count"}, bus_a.sbe_count, es);
      check({tag, "_dbe_count"}, bus_a.dbe_count, eb);
      check({tag, "_err_valid"}, bus_a.err_valid, ev);
      check({tag, "_err_addr"},  bus_a.err_addr, ea);
    end else begin
      check({tag, "_sbe_count"}, bus_b.sbe_count, es);
      check({tag, "_dbe_count"}, bus_b.dbe_count, eb);
      check({tag, "_err_valid"}, bus_b.err_valid, ev);
      check({tag, "_err_addr"},  bus_b.err_addr, ea);
    end
  endtask

  task automatic chk_reset_outputs(input int sel, input string tag);
    if (sel == 0) begin
      check({tag, "_rvalid"}, bus_a.rvalid, 0);
      check({tag, "_rdata"},  bus_a.rdata, 0);
      check({tag, "_flags"},  {bus_a.rsbe, bus_a.rdbe, bus_a.scrub_busy}, 0);
      check({tag, "_state"},  bus_a.scrub_state, 0);
    end else begin
      check({tag, "_rvalid"}, bus_b.rvalid, 0);
      check({tag, "_rdata"},  bus_b.rdata, 0);
      check({tag, "_flags"},  {bus_b.rsbe, bus_b.rdbe, bus_b.scrub_busy}, 0);
      check({tag, "_state"},  bus_b.scrub_state, 0);
    end
    chk_err(sel, tag, 0, 0, 1'b0, '0);
  endtask

  task automatic pulse_reset_b();
    @(posedge clk); #2;
    rst_v[1] = 1'b1;
    #4;
    rst_v[1] = 1'b0;
    @(posedge clk); #1;
  endtask

  // bounded wait for a scrubber state on instance b
  task automatic wait_state_b(input logic [2:0] st, input string tag);
    int n;
    n = 0;
    while (bus_b.scrub_state !== st && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_reached"}, bus_b.scrub_state, st);
  endtask

  // Hand-computed vectors. Data positions: bit0@3, bit1@5, bit2@6, bit3@7,
  // bit4@9, bit5@10, ..., bit56@63. Position 4 is check bit 2, bit 0 is parity.
  localparam logic [DW-1:0] D1 = 57'h123456789ABCDE;
  localparam logic [DW-1:0] D2 = 57'h15A5A5A5A5A5A5;
  localparam logic [DW-1:0] D3 = 57'h0F0F0F0F0F0F0F;
  localparam logic [DW-1:0] D3_RAW = 57'h0F0F0F0F0F0F0C;
  localparam logic [DW-1:0] D4 = 57'h0000000000FFFF;
  localparam logic [DW-1:0] D5 = 57'h1FFFFFFFFFFFFF;
  localparam logic [DW-1:0] D7 = 57'h0AAAAAAAAAAAAA;
  localparam logic [DW-1:0] D8 = 57'h13579BDF2468AC;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_v[i] = 1'b1; we_v[i] = 1'b0; waddr_v[i] = '0; wdata_v[i] = '0;
      mask_v[i] = '0; re_v[i] = 1'b0; raddr_v[i] = '0; clr_v[i] = 1'b0;
    end
    #22;
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;
    #1;
    chk_reset_outputs(0, "a_reset");
    chk_reset_outputs(1, "b_reset");
    @(posedge clk); #1;

    // clean write then read next cycle
    do_write(0, 4'd3, D1, '0);
    do_read(0, 4'd3, D1, 1'b0, 1'b0);
    idle(2);
    chk_err(0, "clean", 0, 0, 1'b0, 4'd0);

    // same-cycle read and write of one address returns old contents
    we_v[0] = 1'b1; waddr_v[0] = 4'd3; wdata_v[0] = D7;
    re_v[0] = 1'b1; raddr_v[0] = 4'd3;
    push_exp(0, D1, 1'b0, 1'b0);
    @(posedge clk); #1;
    we_v[0] = 1'b0; re_v[0] = 1'b0;
    do_read(0, 4'd3, D7, 1'b0, 1'b0);

    // single data-bit error (data bit 5 -> position 10)
    do_write(0, 4'd5, D2, 64'h400);
    do_read(0, 4'd5, D2, 1'b1, 1'b0);
    idle(2);
    chk_err(0, "sbe", 1, 0, 1'b1, 4'd5);

    // double error (positions 3 and 5 = data bits 0 and 1)
    do_write(0, 4'd9, D3, 64'h28);
    do_read(0, 4'd9, D3_RAW, 1'b0, 1'b1);
    idle(2);
    chk_err(0, "dbe", 1, 1, 1'b1, 4'd5);

    // check-bit-only flip, then overall-parity-only flip
    do_write(0, 4'd6, D4, 64'h10);
    do_write(0, 4'd7, D5, 64'h1);
    do_read(0, 4'd6, D4, 1'b1, 1'b0);
    do_read(0, 4'd7, D5, 1'b1, 1'b0);
    idle(2);
    chk_err(0, "chk_par", 3, 1, 1'b1, 4'd5);

    // highest position (data bit 56); counter already saturated at 3
    do_write(0, 4'd10, '0, 64'h8000000000000000);
    do_read(0, 4'd10, '0, 1'b1, 1'b0);
    idle(2);
    chk_err(0, "top_bit", 3, 1, 1'b1, 4'd5);

    // clear, then five back-to-back sbe reads saturate at 3
    clr_v[0] = 1'b1;
    @(posedge clk); #1;
    clr_v[0] = 1'b0;
    chk_err(0, "clear", 0, 0, 1'b0, 4'd0);
    for (int i = 0; i < 5; i++) do_read(0, 4'd5, D2, 1'b1, 1'b0);
    idle(2);
    chk_err(0, "saturate", 3, 0, 1'b1, 4'd5);

    // clear coinciding with a dbe event: cleared first, then event applied
    do_read(0, 4'd9, D3_RAW, 1'b0, 1'b1);
    clr_v[0] = 1'b1;
    @(posedge clk); #1;
    clr_v[0] = 1'b0;
    chk_err(0, "clr_coincide", 0, 1, 1'b1, 4'd9);

    // scrub repair of a single error at addr 0
    pulse_reset_b();
    do_write(1, 4'd0, D2, 64'h400);
    idle(16);
    chk_err(1, "scrub_fix", 1, 0, 1'b1, 4'd0);
    do_read(1, 4'd0, D2, 1'b0, 1'b0);
    idle(2);

    // host write to addr 0 during CHECK cancels the write-back
    pulse_reset_b();
    do_write(1, 4'd0, D2, 64'h400);
    wait_state_b(3'd3, "check");
    do_write(1, 4'd0, D8, '0);
    idle(3);
    do_read(1, 4'd0, D8, 1'b0, 1'b0);
    idle(2);
    chk_err(1, "cancel", 1, 0, 1'b1, 4'd0);

    // reset asserted during WRITE aborts the write-back and clears everything
    pulse_reset_b();
    do_write(1, 4'd0, D2, 64'h400);
    wait_state_b(3'd4, "write");
    check("pre_rst_sbe_count", bus_b.sbe_count, 1);
    #2;
    rst_v[1] = 1'b1;
    #1;
    chk_reset_outputs(1, "mid_rst");
    #3;
    rst_v[1] = 1'b0;
    @(posedge clk); #1;
    do_read(1, 4'd0, '0, 1'b0, 1'b0);
    do_read(1, 4'd5, '0, 1'b0, 1'b0);
    idle(2);
    chk_err(1, "post_rst", 0, 0, 1'b0, 4'd0);

    idle(3);
    check("a_queue_drained", exp_a.size(), 0);
    check("b_queue_drained", exp_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1);
  end
endmodule
